// File: rtl/hazard_stall_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller_if
//   Bundles the pipeline-side signals of the hazard/stall controller.
//   The pipeline (master) supplies the decoded ID/EX hazard information and
//   consumes the interlock controls. The controller (slave) does the reverse.
//
//   Pipeline -> controller:
//     ID_rs, ID_rt     source register fields of the instruction in ID
//     ID_UsesRt        ID instruction reads rt as a source
//     EX_MemRead       instruction in EX is a load
//     EX_rt            destination register of the load in EX
//     ID_MduStart      ID instruction is mult/multu/div/divu
//     ID_MduRead       ID instruction is mfhi/mflo
//     ID_BranchTaken   branch in ID resolved taken, or jump in ID
//   Controller -> pipeline:
//     PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble   interlock controls
//     MDU_Start        one-cycle start pulse to the MDU
//     MDU_Busy         MDU still counting down its latency
//     Stall_Count      saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
interface hazard_stall_controller_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        ID_rs;
  logic [4:0]        ID_rt;
  logic              ID_UsesRt;
  logic              EX_MemRead;
  logic [4:0]        EX_rt;
  logic              ID_MduStart;
  logic              ID_MduRead;
  logic              ID_BranchTaken;

  logic              PC_Write;
  logic              IFID_Write;
  logic              IFID_Flush;
  logic              IDEX_Bubble;
  logic              MDU_Start;
  logic              MDU_Busy;
  logic [PERF_W-1:0] Stall_Count;

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt,
           ID_MduStart, ID_MduRead, ID_BranchTaken,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
           MDU_Start, MDU_Busy, Stall_Count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt,
           ID_MduStart, ID_MduRead, ID_BranchTaken,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
           MDU_Start, MDU_Busy, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//   Pipeline interlock sequencer for the 5-stage MIPS core. Handles the hazards
//   forwarding cannot: stalls IF/ID on load-use and while the multiply/divide
//   unit is busy, squashes IF/ID on a taken branch/jump, issues MDU start
//   pulses and keeps a saturating stall-cycle counter.
//
//   Ports:
//     clk       rising-edge clock
//     reset_n   asynchronous active-low reset
//     hz        slave side of hazard_stall_controller_if (hazard inputs,
//               interlock outputs, MDU start/busy, Stall_Count)
//
//   Parameters:
//     MDU_LATENCY  cycles the MDU stays busy after an accepted start
//                  (legal range 1 .. 2**CNT_W-1)
//     CNT_W        width of the MDU busy down-counter
//     PERF_W       width of Stall_Count; must match the interface PERF_W
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hazard_stall_controller_if.slave hz
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(MDU_LATENCY);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PERF_W-1:0] stall_count;

  logic mdu_busy;
  logic lu;
  logic mduh;
  logic stall;
  logic mdu_start;

  // The FSM state mirrors (cnt != 0); it is kept so the busy flag comes
  // straight from a flop rather than a CNT_W-wide OR.
  assign mdu_busy = (state == MDU_BUSY);

  // Hazard detection. $0 is hardwired to zero, so a load into it can never
  // produce a value the ID instruction has to wait for.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    lu        = 1'b0;
    mduh      = 1'b0;
    stall     = 1'b0;
    mdu_start = 1'b0;

    lu = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
         ((hz.EX_rt == hz.ID_rs) || (hz.ID_UsesRt && (hz.EX_rt == hz.ID_rt)));
    // A new start while busy is held here too, so the counter is never
    // reloaded mid-count.
    mduh      = mdu_busy && (hz.ID_MduRead || hz.ID_MduStart);
    stall     = lu || mduh;
    mdu_start = hz.ID_MduStart && !stall;
  end

  // Stall wins over flush: a branch held in ID re-resolves once the stall
  // clears, so squashing IF/ID now would drop the delay-slot fetch twice.
  assign hz.PC_Write    = !stall;
  assign hz.IFID_Write  = !stall;
  assign hz.IDEX_Bubble = stall;
  assign hz.IFID_Flush  = !stall && hz.ID_BranchTaken;
  assign hz.MDU_Start   = mdu_start;
  assign hz.MDU_Busy    = mdu_busy;
  assign hz.Stall_Count = stall_count;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every flop here carries control meaning, so all are reset;
      // an in-flight MDU operation is simply abandoned.
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      if (mdu_start) begin
        cnt   <= LAT_LOAD;
        state <= MDU_BUSY;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state <= RUN;
        end
      end

      if (stall && (stall_count != PERF_MAX)) begin
        stall_count <= stall_count + PERF_W'(1);
      end
    end
  end

endmodule
